// File: rtl/sa_tile_sequencer.sv
// Tile sequencer for an NxN systolic array: LOAD_W -> FEED -> DRAIN -> READ -> DONE, Moore outputs.
// Outputs follow the registered state; there is no backpressure, and abort returns to IDLE on the next edge.
module sa_tile_sequencer #(
    parameter int N     = 128,
    parameter int CNT_W = 8,
    parameter int KW    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             skip_wload,
    input  logic [KW-1:0]    k_len,
    input  logic             abort,
    output logic             busy,
    output logic             w_load_en,
    output logic [CNT_W-1:0] w_row,
    output logic             x_feed_en,
    output logic [CNT_W-1:0] x_idx,
    output logic             acc_clear,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_row,
    output logic             done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_W = 3'd1;
    localparam logic [2:0] S_FEED   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int             XW     = CNT_W + KW;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_N  = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] LAST_D  = CNT_W'(2 * N - 2);
    localparam logic [XW-1:0]    X_ONE   = XW'(1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [KW-1:0]    klen_q, klen_d;

    logic [XW-1:0] cnt_ext;
    logic [XW-1:0] klen_ext;
    logic          feed_last;

    // Compare in a common width so k_len and the counter may differ in size.
    assign cnt_ext   = {{KW{1'b0}}, cnt_q};
    assign klen_ext  = {{CNT_W{1'b0}}, klen_q};
    assign feed_last = (cnt_ext + X_ONE) == klen_ext;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_ONE;
        klen_d  = klen_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // skip_wload only steers this exit, so it needs no register of its own.
                if (start) begin
                    klen_d = k_len;
                    if (!skip_wload)
                        state_d = S_LOAD_W;
                    else if (k_len != '0)
                        state_d = S_FEED;
                    else
                        state_d = S_DRAIN;
                end
            end
            S_LOAD_W: if (cnt_q == LAST_N) state_d = (klen_q != '0) ? S_FEED : S_DRAIN;
            S_FEED:   if (feed_last)       state_d = S_DRAIN;
            S_DRAIN:  if (cnt_q == LAST_D) state_d = S_READ;
            S_READ:   if (cnt_q == LAST_N) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        if (abort && state_q != S_IDLE)
            state_d = S_IDLE;
        if (state_d != state_q)
            cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            klen_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            klen_q  <= klen_d;
        end
    end

    always_comb begin
        busy      = state_q != S_IDLE;
        w_load_en = 1'b0;
        w_row     = '0;
        x_feed_en = 1'b0;
        x_idx     = '0;
        acc_clear = 1'b0;
        out_valid = 1'b0;
        out_row   = '0;
        done      = 1'b0;
        case (state_q)
            S_LOAD_W: begin
                w_load_en = 1'b1;
                w_row     = cnt_q;
            end
            S_FEED: begin
                x_feed_en = 1'b1;
                x_idx     = cnt_q;
                acc_clear = cnt_q == '0;
            end
            // With no activations the accumulators are still cleared once per tile.
            S_DRAIN:  acc_clear = (klen_q == '0) && (cnt_q == '0);
            S_READ: begin
                out_valid = 1'b1;
                out_row   = cnt_q;
            end
            S_DONE:   done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sa_tile_sequencer.sv
// Randomized and directed bench for sa_tile_sequencer (N=4) against a per-cycle expected-trace model.
// A tile is expanded into its output sequence when accepted; each cycle pops one entry.
module tb_sa_tile_sequencer;

    localparam int N = 4;

    typedef struct packed {
        logic       busy;
        logic       w_load_en;
        logic [3:0] w_row;
        logic       x_feed_en;
        logic [3:0] x_idx;
        logic       acc_clear;
        logic       out_valid;
        logic [3:0] out_row;
        logic       done;
    } obs_t;

    logic       clk;
    logic       rstn;
    logic       start;
    logic       skip_wload;
    logic [3:0] k_len;
    logic       abort;
    logic       busy;
    logic       w_load_en;
    logic [3:0] w_row;
    logic       x_feed_en;
    logic [3:0] x_idx;
    logic       acc_clear;
    logic       out_valid;
    logic [3:0] out_row;
    logic       done;

    int   n_checks;
    int   n_errors;
    int   cyc_n;
    obs_t exp_q[$];
    int   run_len;
    bit   run_void;
    int   exp_len;

    sa_tile_sequencer #(.N(N), .CNT_W(4), .KW(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .skip_wload (skip_wload),
        .k_len      (k_len),
        .abort      (abort),
        .busy       (busy),
        .w_load_en  (w_load_en),
        .w_row      (w_row),
        .x_feed_en  (x_feed_en),
        .x_idx      (x_idx),
        .acc_clear  (acc_clear),
        .out_valid  (out_valid),
        .out_row    (out_row),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic obs_t dut_obs();
        obs_t o;
        o.busy      = busy;
        o.w_load_en = w_load_en;
        o.w_row     = w_row;
        o.x_feed_en = x_feed_en;
        o.x_idx     = x_idx;
        o.acc_clear = acc_clear;
        o.out_valid = out_valid;
        o.out_row   = out_row;
        o.done      = done;
        return o;
    endfunction

    // Expand one tile into the exact output sequence it must produce.
    function automatic void push_tile(input bit sk, input int kl);
        obs_t v;
        if (!sk) begin
            for (int i = 0; i < N; i++) begin
                v = '0; v.busy = 1'b1; v.w_load_en = 1'b1; v.w_row = 4'(i);
                exp_q.push_back(v);
            end
        end
        for (int i = 0; i < kl; i++) begin
            v = '0; v.busy = 1'b1; v.x_feed_en = 1'b1; v.x_idx = 4'(i); v.acc_clear = (i == 0);
            exp_q.push_back(v);
        end
        for (int i = 0; i < 2 * N - 1; i++) begin
            v = '0; v.busy = 1'b1; v.acc_clear = (kl == 0) && (i == 0);
            exp_q.push_back(v);
        end
        for (int i = 0; i < N; i++) begin
            v = '0; v.busy = 1'b1; v.out_valid = 1'b1; v.out_row = 4'(i);
            exp_q.push_back(v);
        end
        v = '0; v.busy = 1'b1; v.done = 1'b1;
        exp_q.push_back(v);
    endfunction

    task automatic sample();
        obs_t e;
        @(negedge clk);
        cyc_n++;
        e = (exp_q.size() != 0) ? exp_q[0] : '0;
        check($sformatf("cyc%0d", cyc_n), 32'(dut_obs()), 32'(e));
        if (busy) begin
            run_len++;
        end else begin
            if (run_len > 0 && !run_void)
                check("busy_len", 32'(run_len), 32'(exp_len));
            run_len = 0;
        end
    endtask

    task automatic drive(input bit rs, input bit st, input bit sk, input logic [3:0] kl, input bit ab);
        rstn = rs; start = st; skip_wload = sk; k_len = kl; abort = ab;
        if (!rs) begin
            exp_q.delete();
            run_void = 1'b1;
        end else if (exp_q.size() != 0) begin
            if (ab) begin
                exp_q.delete();
                run_void = 1'b1;
            end else begin
                void'(exp_q.pop_front());
            end
        end else if (st) begin
            push_tile(sk, int'(kl));
            exp_len  = (sk ? 0 : N) + int'(kl) + (2 * N - 1) + N + 1;
            run_void = 1'b0;
        end
    endtask

    task automatic cyc(input bit rs, input bit st, input bit sk, input logic [3:0] kl, input bit ab);
        sample();
        drive(rs, st, sk, kl, ab);
    endtask

    initial begin
        bit found;
        n_checks = 0; n_errors = 0; cyc_n = 0;
        run_len = 0; run_void = 1'b1; exp_len = 0;
        rstn = 1'b0; start = 1'b0; skip_wload = 1'b0; k_len = '0; abort = 1'b0;

        // Reset with random inputs, then idle after release.
        for (int i = 0; i < 5; i++)
            cyc(1'b0, 1'(($urandom)), 1'(($urandom)), 4'($urandom), 1'(($urandom)));
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Full tile, then skip with k_len=0.
        cyc(1'b1, 1'b1, 1'b0, 4'd3, 1'b0);
        for (int i = 0; i < 22; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Start held high: back-to-back tiles with a single idle cycle between.
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 4'd1, 1'b0);
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Abort during FEED at x_idx=1.
        cyc(1'b1, 1'b1, 1'b1, 4'd3, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            sample();
            if (x_feed_en && x_idx == 4'd1) begin
                found = 1'b1;
                break;
            end
            drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        if (!found) check("abort_wait_timeout", 32'(found), 32'd1);
        drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 4'd2, 1'b0);
        for (int i = 0; i < 22; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        // abort together with start in IDLE: start wins.
        cyc(1'b1, 1'b1, 1'b0, 4'd2, 1'b1);
        for (int i = 0; i < 22; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Asynchronous reset in the middle of READ.
        cyc(1'b1, 1'b1, 1'b1, 4'd1, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            sample();
            if (out_valid && out_row == 4'd2) begin
                found = 1'b1;
                break;
            end
            drive(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        end
        if (!found) check("read_wait_timeout", 32'(found), 32'd1);
        #2 rstn = 1'b0;
        #1 check("async_rst", 32'(dut_obs()), 32'd0);
        drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        // Randomized traffic with occasional aborts.
        for (int i = 0; i < 1500; i++)
            cyc(1'b1, ($urandom % 6) == 0, 1'(($urandom)),
                (($urandom % 4) == 0) ? 4'd0 : 4'($urandom), ($urandom % 50) == 0);
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
